shader_spi_loader: RTL and testbench



---
 rtl/shader_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 39 +++
 rtl/shader_spi_loader.sv | 161 ++++++++++++++++
 tb/tb_shader_spi_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/shader_pkg.sv
// Shared definitions for the shader SPI loader: command bytes, FSM states, word width.
package shader_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic [7:0] CMD_WRITE_MEM = 8'h00;
    localparam logic [7:0] CMD_READ_MEM  = 8'h01;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        READ,
        DRAIN
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the SPI pins into the clk domain and produces one-cycle edge pulses
// for sclk (rise/fall) and cs (fall = frame start, rise = frame end).
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic mosi_sync
);

    // [0] first flop, [1] synchronized level, [2] one cycle older for edge detect
    logic [2:0] sclk_sr;
    logic [2:0] cs_sr;
    logic [1:0] mosi_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sr <= 3'b000;
            cs_sr   <= 3'b111;
            mosi_sr <= 2'b00;
        end else begin
            sclk_sr <= {sclk_sr[1:0], sclk};
            cs_sr   <= {cs_sr[1:0], cs};
            mosi_sr <= {mosi_sr[0], mosi};
        end
    end

    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    assign cs_rise   = cs_sr[1] & ~cs_sr[2];
    assign cs_fall   = ~cs_sr[1] & cs_sr[2];
    assign mosi_sync = mosi_sr[1];

endmodule

// File: rtl/shader_spi_loader.sv
// SPI mode-0 slave that streams a shader program into instruction memory.
// Define SPI_READBACK_EN to add command 0x01, which streams memory back on MISO.
module shader_spi_loader #(
    parameter int MEM_DEPTH  = 16,
    parameter int DATA_WIDTH = shader_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sclk,
    input  logic                  spi_cs,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    import shader_pkg::*;

    localparam int BCW = $clog2(DATA_WIDTH);
    localparam logic [BCW-1:0]        LAST_BIT  = BCW'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                state_q, state_d;
    logic                  sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_sync;
    logic [BCW-1:0]        bit_cnt;
    logic [DATA_WIDTH-2:0] shift_q;
    logic [DATA_WIDTH-1:0] byte_val;
    logic                  byte_done;
    logic                  rd_adv;
    logic [ADDR_WIDTH-1:0] addr_inc;

    spi_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (spi_sclk),
        .cs        (spi_cs),
        .mosi      (spi_mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .mosi_sync (mosi_sync)
    );

    // byte_val is the full byte as it stands after the current rising edge
    assign byte_val  = {shift_q, mosi_sync};
    assign byte_done = sclk_rise && (bit_cnt == LAST_BIT);
    assign addr_inc  = (mem_addr == LAST_ADDR) ? '0 : mem_addr + ADDR_WIDTH'(1);
    assign busy      = (state_q == WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) state_d = CMD;
                CMD: begin
                    if (byte_done) begin
                        if (byte_val == DATA_WIDTH'(CMD_WRITE_MEM))
                            state_d = WRITE;
`ifdef SPI_READBACK_EN
                        else if (byte_val == DATA_WIDTH'(CMD_READ_MEM))
                            state_d = READ;
`endif
                        else
                            state_d = DRAIN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_q   <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_addr  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (state_q == IDLE && cs_fall) begin
                bit_cnt <= '0;
                shift_q <= '0;
            end else if (sclk_rise && !cs_rise && (state_q == CMD || state_q == WRITE)) begin
                shift_q <= byte_val[DATA_WIDTH-2:0];
                bit_cnt <= byte_done ? '0 : bit_cnt + BCW'(1);
            end

            // cs_rise on the same cycle means the frame ended; the byte is dropped
            if (state_q == WRITE && byte_done && !cs_rise) begin
                mem_we    <= 1'b1;
                mem_wdata <= byte_val;
            end

            if (state_q == CMD && (state_d == WRITE || state_d == READ))
                mem_addr <= '0;
            else if (mem_we || rd_adv)
                mem_addr <= addr_inc;
        end
    end

`ifdef SPI_READBACK_EN
    logic [DATA_WIDTH-1:0] out_sr;
    logic [BCW-1:0]        rd_cnt;
    logic                  rd_first, rd_load;

    // The falling edge that closes the command byte must not shift out the
    // first data bit, so rd_first swallows it.
    assign rd_adv = (state_q == READ) && sclk_fall && !rd_load && !rd_first
                    && (rd_cnt == LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sr   <= '0;
            rd_cnt   <= '0;
            rd_first <= 1'b0;
            rd_load  <= 1'b0;
        end else begin
            rd_load <= 1'b0;
            if (state_q == CMD && state_d == READ) begin
                rd_load  <= 1'b1;
                rd_first <= 1'b1;
                rd_cnt   <= '0;
            end else if (rd_load) begin
                out_sr <= mem_rdata;
            end else if (state_q == READ && sclk_fall) begin
                if (rd_first) begin
                    rd_first <= 1'b0;
                end else if (rd_cnt == LAST_BIT) begin
                    rd_cnt  <= '0;
                    rd_load <= 1'b1;
                end else begin
                    rd_cnt <= rd_cnt + BCW'(1);
                    out_sr <= {out_sr[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    assign spi_miso = (state_q == READ) && out_sr[DATA_WIDTH-1];
`else
    logic unused_rdata;

    assign unused_rdata = ^mem_rdata;
    assign rd_adv       = 1'b0;
    assign spi_miso     = 1'b0;
`endif

endmodule

// File: tb/tb_shader_spi_loader.sv
// Bench for shader_spi_loader: host-side SPI driver, attached memory, and a
// write scoreboard fed by a frame-level model of what the host sent.
module tb_shader_spi_loader;
    import shader_pkg::*;

    localparam int DEPTH = 16;
    localparam int HALF  = 8;

    logic       clk = 1'b0;
    logic       rst, spi_sclk, spi_cs, spi_mosi, spi_miso, mem_we, busy;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    logic [7:0]  shader_mem [DEPTH] = '{default: 8'h00};
    logic [7:0]  ref_mem    [DEPTH] = '{default: 8'h00};
    logic [11:0] exp_q [$];
    logic [7:0]  tx_q  [$];
    int          wp     = 0;
    int          checks = 0;
    int          errors = 0;
    logic        prev_we = 1'b0;

    always #5 clk = ~clk;

    shader_spi_loader #(.MEM_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_sclk  (spi_sclk),
        .spi_cs    (spi_cs),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    assign mem_rdata = shader_mem[mem_addr];
    always @(posedge clk) if (mem_we) shader_mem[mem_addr] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe is matched against the next expected write
    always @(negedge clk) begin
        logic [11:0] e;
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", mem_addr, e[11:8]);
                check("write_data", mem_wdata, e[7:0]);
            end
            check("busy_during_write", busy, 1);
            check("we_one_cycle", prev_we, 0);
        end
        prev_we = mem_we;
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode 0 host: MOSI set while sclk low, MISO sampled just before the rise
    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = b[7-i];
            clk_wait(HALF);
            rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            clk_wait(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic end_frame();
        clk_wait(HALF);
        spi_cs = 1'b1;
        clk_wait(2 * HALF);
        spi_mosi = 1'b0;
    endtask

    task automatic write_frame(input int part_bits, input bit gaps);
        logic [7:0] rx;
        spi_cs = 1'b0;
        clk_wait(HALF);
        spi_bits(CMD_WRITE_MEM, 8, rx);
        check("miso_low_cmd", rx, 0);
        check("busy_in_write", busy, 1);
        wp = 0;
        foreach (tx_q[i]) begin
            exp_q.push_back({wp[3:0], tx_q[i]});
            ref_mem[wp] = tx_q[i];
            wp = (wp + 1) % DEPTH;
            spi_bits(tx_q[i], 8, rx);
            check("miso_low_write", rx, 0);
            if (gaps) clk_wait($urandom_range(0, 6));
        end
        if (part_bits > 0) spi_bits(8'($urandom), part_bits, rx);
        end_frame();
        check("busy_after_frame", busy, 0);
        check("addr_hold", mem_addr, wp);
    endtask

    task automatic other_frame(input logic [7:0] cmd);
        logic [7:0] rx;
        spi_cs = 1'b0;
        clk_wait(HALF);
        spi_bits(cmd, 8, rx);
        check("miso_low_cmd", rx, 0);
        check("busy_low_drain", busy, 0);
        foreach (tx_q[i]) begin
            spi_bits(tx_q[i], 8, rx);
            check("miso_low_drain", rx, 0);
        end
        end_frame();
        check("busy_after_drain", busy, 0);
    endtask

    task automatic read_frame(input int n);
`ifdef SPI_READBACK_EN
        logic [7:0] rx;
        spi_cs = 1'b0;
        clk_wait(HALF);
        spi_bits(CMD_READ_MEM, 8, rx);
        check("miso_low_cmd", rx, 0);
        check("busy_low_read", busy, 0);
        for (int i = 0; i < n; i++) begin
            spi_bits(8'($urandom), 8, rx);
            check("read_miso", rx, ref_mem[i % DEPTH]);
        end
        end_frame();
`else
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
        other_frame(CMD_READ_MEM);
`endif
    endtask

    task automatic reset_mid_frame();
        logic [7:0] rx;
        spi_cs = 1'b0;
        clk_wait(HALF);
        spi_bits(CMD_WRITE_MEM, 8, rx);
        exp_q.push_back({4'h0, 8'hC3});
        ref_mem[0] = 8'hC3;
        spi_bits(8'hC3, 8, rx);
        spi_bits(8'hFF, 3, rx);
        spi_mosi = 1'b1;
        spi_sclk = 1'b1;
        clk_wait(3);
        rst = 1'b1;
        #1;
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_miso", spi_miso, 0);
        clk_wait(4);
        spi_cs   = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        clk_wait(4);
        rst = 1'b0;
        clk_wait(4);
        check("busy_after_rst", busy, 0);
        wp = 0;
    endtask

    initial begin
        int k, n;
        rst      = 1'b1;
        spi_sclk = 1'b0;
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        clk_wait(3);
        check("init_mem_we", mem_we, 0);
        check("init_mem_addr", mem_addr, 0);
        check("init_mem_wdata", mem_wdata, 0);
        check("init_busy", busy, 0);
        check("init_miso", spi_miso, 0);
        rst = 1'b0;
        clk_wait(3);

        tx_q = '{8'hA5, 8'h3C, 8'hFF};
        write_frame(0, 0);

        tx_q.delete();
        for (int v = 16; v <= 32; v++) tx_q.push_back(8'(v));
        write_frame(0, 0);

        tx_q = '{8'h55};
        write_frame(4, 0);

        tx_q = '{8'h11, 8'h22};
        other_frame(8'h7E);

        tx_q = '{8'hA5, 8'h3C};
        write_frame(0, 0);
        read_frame(2);

        reset_mid_frame();
        tx_q = '{8'h5A};
        write_frame(0, 0);

        for (int f = 0; f < 20; f++) begin
            k = $urandom_range(0, 3);
            n = $urandom_range(0, 10);
            tx_q.delete();
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
            case (k)
                0, 1: write_frame(($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0, 1'b1);
                2:    other_frame(8'($urandom_range(2, 255)));
                default: read_frame($urandom_range(1, 4));
            endcase
        end

        clk_wait(20);
        check("pending_writes", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
